// File: rtl/packet_arbiter.sv
// packet_arbiter: merges NUM_PORTS packet streams onto one 64-bit output.
// A port is chosen round-robin when it presents a sop word while the block is
// idle. The block then stays locked to that port until its eop word. Words that
// arrive without sop while idle are orphans: they are accepted and discarded.
// The output stream is registered: each accepted word appears one cycle later.
module packet_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    cfg_port_en,
  input  logic [NUM_PORTS-1:0]    in_valid,
  input  logic [NUM_PORTS*64-1:0] in_data,
  input  logic [NUM_PORTS*8-1:0]  in_byte_enable,
  input  logic [NUM_PORTS-1:0]    in_sop,
  input  logic [NUM_PORTS-1:0]    in_eop,
  output logic [NUM_PORTS-1:0]    in_ready,
  output logic                    out_valid,
  output logic [63:0]             out_data,
  output logic [7:0]              out_byte_enable,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic [2:0]              grant_port,
  output logic [31:0]             pkt_count,
  output logic [15:0]             drop_count,
  output logic                    err_sop
);

  typedef enum logic {
    ST_IDLE = 1'b0,  // no packet in progress
    ST_BUSY = 1'b1   // locked to grant_port_q until its eop
  } state_e;

  // After reset the search starts just past the last port, so port 0 wins first.
  localparam logic [2:0] LAST_PORT = 3'(NUM_PORTS - 1);

  // FSM and grant bookkeeping
  state_e      state_q, state_d;
  logic [2:0]  last_grant_q, last_grant_d;
  logic [2:0]  grant_port_q, grant_port_d;

  // Registered output stream
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_data_q, out_data_d;
  logic [7:0]  out_be_q, out_be_d;
  logic        out_sop_q, out_sop_d;
  logic        out_eop_q, out_eop_d;

  // Status counters and flags
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [15:0] drop_count_q, drop_count_d;
  logic        err_sop_q, err_sop_d;

  // Arbitration results
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] orphan;
  logic                 win_found;
  logic [2:0]           win_idx;

  // The port being served this cycle and its input word
  logic [2:0]  sel_port;
  logic        sel_valid;
  logic [63:0] sel_data;
  logic [7:0]  sel_be;
  logic        sel_sop;
  logic        sel_eop;
  logic        accept;

  // Orphan accounting
  logic [3:0]  orphan_cnt;
  logic [16:0] drop_sum;

  // Round-robin pick of the first eligible sop port after last_grant_q.
  always_comb begin
    // NOTE: every signal written in an always_comb gets a default first, so
    // that no path leaves it unassigned and a latch is never inferred.
    eligible  = in_valid & in_sop & cfg_port_en;
    orphan    = in_valid & ~in_sop & cfg_port_en;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!win_found && eligible[i] &&
            (i == (int'(last_grant_q) + k) % NUM_PORTS)) begin
          win_found = 1'b1;
          win_idx   = 3'(i);
        end
      end
    end
  end

  // Select the word of the served port: the held grant when busy, else the winner.
  always_comb begin
    sel_port  = (state_q == ST_BUSY) ? grant_port_q : win_idx;
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_be    = '0;
    sel_sop   = 1'b0;
    sel_eop   = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_port == 3'(i)) begin
        sel_valid = in_valid[i];
        sel_data  = in_data[i*64 +: 64];
        sel_be    = in_byte_enable[i*8 +: 8];
        sel_sop   = in_sop[i];
        sel_eop   = in_eop[i];
      end
    end
  end

  // A word of the served port transfers this cycle. When idle, a winner
  // always has in_valid high, so win_found alone implies the transfer.
  assign accept = (state_q == ST_BUSY) ? sel_valid : win_found;

  // Count orphan ports this cycle; they are discarded only while idle.
  always_comb begin
    orphan_cnt = '0;
    if (state_q == ST_IDLE) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        orphan_cnt = orphan_cnt + 4'(orphan[i]);
      end
    end
    drop_sum = {1'b0, drop_count_q} + 17'(orphan_cnt);
  end

  // FSM output decode: in_ready for the winner and orphans when idle, the
  // granted port only when busy, nothing while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (!rst) begin
      if (state_q == ST_IDLE) begin
        in_ready = orphan;
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (win_found && (win_idx == 3'(i))) begin
            in_ready[i] = 1'b1;
          end
        end
      end else begin
        for (int i = 0; i < NUM_PORTS; i++) begin
          if (grant_port_q == 3'(i)) begin
            in_ready[i] = 1'b1;
          end
        end
      end
    end
  end

  // FSM next state: lock on a multi-word sop, release on the granted eop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (win_found && !sel_eop) state_d = ST_BUSY;
      ST_BUSY: if (accept && sel_eop)     state_d = ST_IDLE;
      default:                            state_d = ST_IDLE;
    endcase
  end

  // Next values of the output stream, grant tracking, counters and flags.
  always_comb begin
    out_valid_d  = accept;
    out_data_d   = accept ? sel_data : 64'd0;
    out_be_d     = accept ? sel_be   : 8'd0;
    out_sop_d    = accept && sel_sop;
    out_eop_d    = accept && sel_eop;

    last_grant_d = last_grant_q;
    grant_port_d = grant_port_q;
    if (state_q == ST_IDLE && win_found) begin
      last_grant_d = win_idx;
      grant_port_d = win_idx;
    end

    // Every forwarded eop closes a packet, whether single-word or not.
    pkt_count_d  = pkt_count_q + 32'(accept && sel_eop);

    drop_count_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    // A sop on the locked port is forwarded but flagged; the flag is sticky.
    err_sop_d    = err_sop_q | ((state_q == ST_BUSY) && accept && sel_sop);
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked blocks use non-blocking assignments only, so every flop
    // samples the values from before the edge regardless of statement order.
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grant, output stream and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= LAST_PORT;
      grant_port_q <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_be_q     <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      err_sop_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      grant_port_q <= grant_port_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_be_q     <= out_be_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      pkt_count_q  <= pkt_count_d;
      drop_count_q <= drop_count_d;
      err_sop_q    <= err_sop_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign out_byte_enable = out_be_q;
  assign out_sop         = out_sop_q;
  assign out_eop         = out_eop_q;
  assign grant_port      = grant_port_q;
  assign pkt_count       = pkt_count_q;
  assign drop_count      = drop_count_q;
  assign err_sop         = err_sop_q;

endmodule

// File: tb/tb_packet_arbiter.sv
// Directed testbench for packet_arbiter with hand-computed expected values.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit later, well away from the next rising edge.
module tb_packet_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   cfg_port_en;
  logic [N-1:0]   in_valid;
  logic [N*64-1:0] in_data;
  logic [N*8-1:0] in_byte_enable;
  logic [N-1:0]   in_sop;
  logic [N-1:0]   in_eop;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [63:0]    out_data;
  logic [7:0]     out_byte_enable;
  logic           out_sop;
  logic           out_eop;
  logic [2:0]     grant_port;
  logic [31:0]    pkt_count;
  logic [15:0]    drop_count;
  logic           err_sop;

  int checks = 0;
  int errors = 0;

  packet_arbiter #(.NUM_PORTS(N)) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_port_en     (cfg_port_en),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_byte_enable  (in_byte_enable),
    .in_sop          (in_sop),
    .in_eop          (in_eop),
    .in_ready        (in_ready),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_byte_enable (out_byte_enable),
    .out_sop         (out_sop),
    .out_eop         (out_eop),
    .grant_port      (grant_port),
    .pkt_count       (pkt_count),
    .drop_count      (drop_count),
    .err_sop         (err_sop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic s, input logic e,
                           input logic [7:0] be, input logic [63:0] d);
    check({tag, "_ctl"}, 64'({out_valid, out_sop, out_eop, out_byte_enable}), 64'({v, s, e, be}));
    check({tag, "_data"}, out_data, d);
  endtask

  task automatic drive(input int p, input logic v, input logic s, input logic e,
                       input logic [63:0] d, input logic [7:0] be);
    in_valid[p]                = v;
    in_sop[p]                  = s;
    in_eop[p]                  = e;
    in_data[p*64 +: 64]        = d;
    in_byte_enable[p*8 +: 8]   = be;
  endtask

  task automatic idle_all();
    in_valid       = '0;
    in_sop         = '0;
    in_eop         = '0;
    in_data        = '0;
    in_byte_enable = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    cfg_port_en = '1;
    repeat (2) next_cycle();
    rst = 1'b0;
  endtask

  // Watchdog: the directed sequence is a few hundred cycles at most.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    cfg_port_en = '1;
    idle_all();

    // in_ready stays low while reset is asserted, even with a sop offered.
    drive(0, 1'b1, 1'b1, 1'b1, 64'h1234, 8'hFF);
    #2;
    check("rst_rdy", 64'(in_ready), 64'(4'b0000));
    do_reset();

    // Reset state
    check_out("rst_out", 1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    check("rst_grant", 64'(grant_port), 64'd0);
    check("rst_pkt", 64'(pkt_count), 64'd0);
    check("rst_drop", 64'(drop_count), 64'd0);
    check("rst_err", 64'(err_sop), 64'd0);

    // ---- Ports 0 and 2 present 3-word packets at once ----
    drive(0, 1'b1, 1'b1, 1'b0, 64'hA0A0_0000_0000_0000, 8'hFF);
    drive(2, 1'b1, 1'b1, 1'b0, 64'hC2C2_0000_0000_0000, 8'hFF);
    #1;
    check("t1_rdy0", 64'(in_ready), 64'(4'b0001));
    check_out("t1_out0", 1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    next_cycle();
    drive(0, 1'b1, 1'b0, 1'b0, 64'hA0A0_0000_0000_0001, 8'hFF);
    #1;
    check("t1_rdy1", 64'(in_ready), 64'(4'b0001));
    check("t1_grant1", 64'(grant_port), 64'd0);
    check_out("t1_out1", 1'b1, 1'b1, 1'b0, 8'hFF, 64'hA0A0_0000_0000_0000);
    next_cycle();
    drive(0, 1'b1, 1'b0, 1'b1, 64'hA0A0_0000_0000_0002, 8'hFF);
    #1;
    check("t1_rdy2", 64'(in_ready), 64'(4'b0001));
    check_out("t1_out2", 1'b1, 1'b0, 1'b0, 8'hFF, 64'hA0A0_0000_0000_0001);
    next_cycle();
    drive(0, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00);
    #1;
    check("t1_rdy3", 64'(in_ready), 64'(4'b0100));
    check_out("t1_out3", 1'b1, 1'b0, 1'b1, 8'hFF, 64'hA0A0_0000_0000_0002);
    next_cycle();
    drive(2, 1'b1, 1'b0, 1'b0, 64'hC2C2_0000_0000_0001, 8'hFF);
    #1;
    check("t1_grant4", 64'(grant_port), 64'd2);
    check_out("t1_out4", 1'b1, 1'b1, 1'b0, 8'hFF, 64'hC2C2_0000_0000_0000);
    next_cycle();
    drive(2, 1'b1, 1'b0, 1'b1, 64'hC2C2_0000_0000_0002, 8'hFF);
    #1;
    check_out("t1_out5", 1'b1, 1'b0, 1'b0, 8'hFF, 64'hC2C2_0000_0000_0001);
    next_cycle();
    idle_all();
    #1;
    check_out("t1_out6", 1'b1, 1'b0, 1'b1, 8'hFF, 64'hC2C2_0000_0000_0002);
    next_cycle();
    #1;
    check_out("t1_out7", 1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    check("t1_pkt", 64'(pkt_count), 64'd2);

    // ---- All ports offer 1-word packets continuously: order 0,1,2,3,0 ----
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      if (k < 5) begin
        for (int p = 0; p < N; p++) drive(p, 1'b1, 1'b1, 1'b1, 64'hA0 + 64'(p), 8'hFF);
      end else begin
        idle_all();
      end
      #1;
      if (k > 0) begin
        check($sformatf("t2_grant%0d", k), 64'(grant_port), 64'((k - 1) % N));
        check_out($sformatf("t2_out%0d", k), 1'b1, 1'b1, 1'b1, 8'hFF, 64'hA0 + 64'((k - 1) % N));
      end
      if (k < 5) begin
        check($sformatf("t2_rdy%0d", k), 64'(in_ready), 64'(1) << (k % N));
      end
      next_cycle();
    end
    #1;
    check("t2_pkt", 64'(pkt_count), 64'd5);

    // ---- 13-byte packet on port 1: FF then F8 ----
    do_reset();
    drive(1, 1'b1, 1'b1, 1'b0, 64'h0011_2233_4455_6677, 8'hFF);
    #1;
    check("t3_rdy0", 64'(in_ready), 64'(4'b0010));
    check_out("t3_out0", 1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    next_cycle();
    drive(1, 1'b1, 1'b0, 1'b1, 64'h8899_AABB_CC00_0000, 8'hF8);
    #1;
    check_out("t3_out1", 1'b1, 1'b1, 1'b0, 8'hFF, 64'h0011_2233_4455_6677);
    next_cycle();
    idle_all();
    #1;
    check_out("t3_out2", 1'b1, 1'b0, 1'b1, 8'hF8, 64'h8899_AABB_CC00_0000);
    next_cycle();
    #1;
    check_out("t3_out3", 1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    check("t3_pkt", 64'(pkt_count), 64'd1);

    // ---- Orphan words on port 1 in IDLE ----
    do_reset();
    drive(1, 1'b1, 1'b0, 1'b0, 64'hDEAD_0000_0000_0001, 8'hFF);
    #1;
    check("t4_rdy0", 64'(in_ready), 64'(4'b0010));
    next_cycle();
    drive(1, 1'b1, 1'b0, 1'b1, 64'hDEAD_0000_0000_0002, 8'hFF);
    #1;
    check("t4_rdy1", 64'(in_ready), 64'(4'b0010));
    check_out("t4_out1", 1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    next_cycle();
    idle_all();
    #1;
    check_out("t4_out2", 1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    check("t4_drop", 64'(drop_count), 64'd2);
    check("t4_pkt0", 64'(pkt_count), 64'd0);
    next_cycle();
    // Orphan alongside a winner; the disabled port 2 is ignored entirely.
    cfg_port_en = 4'b1011;
    drive(0, 1'b1, 1'b1, 1'b1, 64'h5151_0000_0000_0000, 8'hFF);
    drive(1, 1'b1, 1'b0, 1'b0, 64'hDEAD_0000_0000_0003, 8'hFF);
    drive(2, 1'b1, 1'b0, 1'b0, 64'hDEAD_0000_0000_0004, 8'hFF);
    #1;
    check("t4_rdy3", 64'(in_ready), 64'(4'b0011));
    next_cycle();
    idle_all();
    cfg_port_en = '1;
    #1;
    check_out("t4_out4", 1'b1, 1'b1, 1'b1, 8'hFF, 64'h5151_0000_0000_0000);
    check("t4_drop2", 64'(drop_count), 64'd3);
    check("t4_pkt1", 64'(pkt_count), 64'd1);

    // ---- Repeated sop mid-packet on the granted port; enable cleared while busy ----
    do_reset();
    drive(2, 1'b1, 1'b1, 1'b0, 64'hE2E2_0000_0000_0000, 8'hFF);
    #1;
    check("t5_rdy0", 64'(in_ready), 64'(4'b0100));
    next_cycle();
    drive(2, 1'b1, 1'b1, 1'b0, 64'hE2E2_0000_0000_0001, 8'hFF);
    #1;
    check_out("t5_out1", 1'b1, 1'b1, 1'b0, 8'hFF, 64'hE2E2_0000_0000_0000);
    check("t5_err1", 64'(err_sop), 64'd0);
    next_cycle();
    cfg_port_en = 4'b1011;
    drive(2, 1'b1, 1'b0, 1'b1, 64'hE2E2_0000_0000_0002, 8'hFF);
    drive(0, 1'b1, 1'b1, 1'b1, 64'h5050_0000_0000_0000, 8'hFF);
    #1;
    check("t5_rdy2", 64'(in_ready), 64'(4'b0100));
    check_out("t5_out2", 1'b1, 1'b1, 1'b0, 8'hFF, 64'hE2E2_0000_0000_0001);
    check("t5_err2", 64'(err_sop), 64'd1);
    next_cycle();
    drive(2, 1'b0, 1'b0, 1'b0, 64'h0, 8'h00);
    #1;
    check("t5_rdy3", 64'(in_ready), 64'(4'b0001));
    check_out("t5_out3", 1'b1, 1'b0, 1'b1, 8'hFF, 64'hE2E2_0000_0000_0002);
    check("t5_pkt3", 64'(pkt_count), 64'd1);
    next_cycle();
    idle_all();
    cfg_port_en = '1;
    #1;
    check_out("t5_out4", 1'b1, 1'b1, 1'b1, 8'hFF, 64'h5050_0000_0000_0000);
    check("t5_pkt4", 64'(pkt_count), 64'd2);
    check("t5_err4", 64'(err_sop), 64'd1);

    // ---- Reset mid-packet on port 3; remaining words become orphans ----
    do_reset();
    check("t6_err_clr", 64'(err_sop), 64'd0);
    drive(3, 1'b1, 1'b1, 1'b0, 64'hF3F3_0000_0000_0000, 8'hFF);
    #1;
    check("t6_rdy0", 64'(in_ready), 64'(4'b1000));
    next_cycle();
    drive(3, 1'b1, 1'b0, 1'b0, 64'hF3F3_0000_0000_0001, 8'hFF);
    rst = 1'b1;
    #1;
    check("t6_rdy1", 64'(in_ready), 64'(4'b0000));
    check_out("t6_out1", 1'b1, 1'b1, 1'b0, 8'hFF, 64'hF3F3_0000_0000_0000);
    next_cycle();
    rst = 1'b0;
    #1;
    check_out("t6_out2", 1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    check("t6_rdy2", 64'(in_ready), 64'(4'b1000));
    next_cycle();
    drive(3, 1'b1, 1'b0, 1'b1, 64'hF3F3_0000_0000_0002, 8'hFF);
    #1;
    check("t6_rdy3", 64'(in_ready), 64'(4'b1000));
    check_out("t6_out3", 1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    next_cycle();
    idle_all();
    drive(0, 1'b1, 1'b1, 1'b1, 64'h0F0F_0000_0000_0000, 8'hFF);
    #1;
    check_out("t6_out4", 1'b0, 1'b0, 1'b0, 8'h00, 64'h0);
    check("t6_drop", 64'(drop_count), 64'd2);
    check("t6_pkt0", 64'(pkt_count), 64'd0);
    check("t6_rdy4", 64'(in_ready), 64'(4'b0001));
    next_cycle();
    idle_all();
    #1;
    check_out("t6_out5", 1'b1, 1'b1, 1'b1, 8'hFF, 64'h0F0F_0000_0000_0000);
    check("t6_pkt1", 64'(pkt_count), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_arbiter.md
PACKET_ARBITER -- requirements
Module: packet_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_PORTS, default 4, giving the number of input packet streams (2..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; every register SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port cfg_port_en, input, NUM_PORTS bits: per-port arbitration enable.
REQ-005 The block SHALL have port in_valid, input, NUM_PORTS bits: per-port word valid.
REQ-006 The block SHALL have port in_data, input, NUM_PORTS*64 bits: port i occupies bits [i*64 +: 64], with byte 0 in the MSB.
REQ-007 The block SHALL have port in_byte_enable, input, NUM_PORTS*8 bits: port i occupies bits [i*8 +: 8].
REQ-008 The block SHALL have ports in_sop and in_eop, input, NUM_PORTS bits each: per-port packet start and packet end.
REQ-009 The block SHALL have port in_ready, output, NUM_PORTS bits: a word transfers on port i when in_valid[i] and in_ready[i] are both high.
REQ-010 The block SHALL have ports out_valid (1), out_data (64), out_byte_enable (8), out_sop (1) and out_eop (1), all outputs: the merged packet stream, which has no backpressure.
REQ-011 The block SHALL have port grant_port, output, 3 bits: index of the current or most recent grant.
REQ-012 The block SHALL have port pkt_count, output, 32 bits: number of packets forwarded, incremented on each forwarded eop.
REQ-013 The block SHALL have port drop_count, output, 16 bits: number of orphan words discarded.
REQ-014 The block SHALL have port err_sop, output, 1 bit: sticky flag set when sop arrives mid-packet on the granted port.

Function
REQ-015 The block SHALL have two states: IDLE (no packet in progress) and BUSY (locked to grant_port until that port's eop).
REQ-016 In IDLE, port i SHALL be eligible when in_valid[i], in_sop[i] and cfg_port_en[i] are all high.
REQ-017 In IDLE, the winner SHALL be the first eligible port searching round-robin from (last_grant+1) mod NUM_PORTS; in_ready SHALL be high only for the winner, combinationally, in the same cycle.
REQ-018 In BUSY, in_ready SHALL be high only for grant_port; all other ports SHALL see in_ready low.
REQ-019 Each accepted word SHALL appear on out_* exactly one cycle after acceptance, with data, byte_enable, sop and eop unmodified.
REQ-020 In any cycle with no accepted word, out_valid SHALL be 0 and out_data, out_byte_enable, out_sop and out_eop SHALL all be 0.
REQ-021 When a sop word without eop is accepted in IDLE, the block SHALL move to BUSY, set grant_port and last_grant to the winner, and hold that grant until eop.
REQ-022 When a word with sop and eop both high is accepted in IDLE (single-word packet), the block SHALL stay in IDLE, update last_grant and increment pkt_count.
REQ-023 When an eop word is accepted in BUSY, the block SHALL return to IDLE on the next edge, so a new sop from any port can be accepted in the following cycle with no bubble.
REQ-024 Clearing cfg_port_en of the granted port while BUSY SHALL NOT abort the packet; the enable mask SHALL affect only the selection made in IDLE.
REQ-025 In IDLE, any enabled port with in_valid high and in_sop low (orphan word) SHALL get in_ready high, its word SHALL be discarded without being forwarded, and drop_count SHALL increment once per orphan port.
REQ-026 Orphan discard SHALL be simultaneous with, and independent of, the winner's sop acceptance.
REQ-027 drop_count SHALL saturate at 16'hFFFF.
REQ-028 pkt_count SHALL wrap modulo 2^32.
REQ-029 An accepted sop word in BUSY on grant_port SHALL be forwarded unchanged and SHALL set err_sop; the state SHALL be unchanged, and err_sop SHALL clear only on reset.
REQ-030 A port with in_valid low SHALL never be granted or counted.

Reset
REQ-031 While rst is high at a clock edge, the block SHALL enter IDLE, set last_grant to NUM_PORTS-1 (so port 0 has first priority), and set grant_port to 0.
REQ-032 While rst is high at a clock edge, the block SHALL clear pkt_count, drop_count and err_sop, and drive all out_* to 0.
REQ-033 While rst is high, in_ready SHALL be all 0.
REQ-034 Reset asserted mid-packet SHALL abandon the packet with no eop emitted; after release, that port's remaining words are orphans subject to REQ-025.

Verification
REQ-035 The bench SHALL cover: ports 0 and 2 each present a 3-word sop at once after reset -> port 0 forwarded first, then port 2 with no gap; out_sop/out_eop in cycles 1/3 and 4/6 after first acceptance; pkt_count=2.
REQ-036 The bench SHALL cover: all 4 ports continuously offer 1-word packets -> grant order 0,1,2,3,0; one packet per cycle.
REQ-037 The bench SHALL cover: a 13-byte packet with byte_enable 8'hFF then 8'hF8 on the eop word -> output identical and delayed one cycle.
REQ-038 The bench SHALL cover: port 1 sends 2 valid words without sop in IDLE -> nothing forwarded; drop_count=2.
REQ-039 The bench SHALL cover: sop repeated mid-packet on the granted port -> word forwarded; err_sop=1; packet ends on eop.
REQ-040 The bench SHALL cover: rst pulsed mid-packet on port 3, then port 3 continues the packet -> its words are dropped; pkt_count=0; the next sop from port 0 is forwarded.
